// File: rtl/cortex_lb_bridge.sv
// -----------------------------------------------------------------------------
// cortex_lb_bridge
//
// Bridges an Avalon-MM style host port onto the cortex local bus. One command
// is outstanding at a time: the host is held off with avs_waitrequest until
// the cortex answers (lb_wr_valid / lb_rd_valid). Read data comes back on
// avs_readdata with a one-cycle avs_readdatavalid strobe.
//
// Optional feature (macro CORTEX_LB_BRIDGE_TIMEOUT_EN):
//   When defined, a 16-bit wait counter forces completion after
//   TIMEOUT_CYCLES cycles without a cortex response. Reads that time out
//   return DEFAULT_DATA_VAL. Each timeout sets the sticky timeout_flag and
//   bumps the saturating timeout_cnt; timeout_clr clears both.
//   When undefined, the bridge waits indefinitely, timeout_flag and
//   timeout_cnt are tied low and timeout_clr is ignored.
//
// Ports
//   clk, rst_n          system clock, synchronous active-low reset
//   avs_address         host word address (LB_ADDR_W)
//   avs_read/avs_write  host read / write request
//   avs_writedata       host write data (LB_DATA_W)
//   avs_waitrequest     high = command not accepted (low only when idle)
//   avs_readdatavalid   one-cycle read-return strobe
//   avs_readdata        read-return data, held between strobes
//   lb_wr_en/lb_rd_en   one-cycle local bus strobes
//   lb_addr/lb_wr_data  command address / data, stable until completion
//   lb_wr_valid         cortex write completion
//   lb_rd_valid         cortex read completion, data on lb_rd_data
//   timeout_clr         clears timeout_flag and timeout_cnt
//   timeout_flag        sticky timeout indicator
//   timeout_cnt         saturating timeout count
// -----------------------------------------------------------------------------
module cortex_lb_bridge #(
  parameter int unsigned              LB_DATA_W        = 32,
  parameter int unsigned              LB_ADDR_W        = 16,
  parameter int unsigned              TIMEOUT_CYCLES   = 256,
  parameter logic [LB_DATA_W-1:0]     DEFAULT_DATA_VAL = 'hdeadbabe
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LB_ADDR_W-1:0] avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [LB_DATA_W-1:0] avs_writedata,
  output logic                 avs_waitrequest,
  output logic                 avs_readdatavalid,
  output logic [LB_DATA_W-1:0] avs_readdata,
  output logic                 lb_wr_en,
  output logic                 lb_rd_en,
  output logic [LB_ADDR_W-1:0] lb_addr,
  output logic [LB_DATA_W-1:0] lb_wr_data,
  input  logic                 lb_wr_valid,
  input  logic                 lb_rd_valid,
  input  logic [LB_DATA_W-1:0] lb_rd_data,
  input  logic                 timeout_clr,
  output logic                 timeout_flag,
  output logic [7:0]           timeout_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  // Wait-counter value on which a still-unanswered command is forced to end.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;

  logic wr_accept;    // write command taken from the host this cycle
  logic rd_accept;    // read command taken from the host this cycle
  logic rd_done;      // cortex read response accepted this cycle
  logic timeout_hit;  // forced completion this cycle
  logic timeout_now;  // wait counter has reached its last value

  // The host is only stalled while a command is outstanding, so reset
  // (which forces IDLE) releases waitrequest immediately.
  assign avs_waitrequest = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Next-state / control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_accept   = 1'b0;
    rd_accept   = 1'b0;
    rd_done     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        // Write has priority; a simultaneous read is consumed and dropped.
        if (avs_write) begin
          wr_accept = 1'b1;
          state_d   = WR_WAIT;
        end else if (avs_read) begin
          rd_accept = 1'b1;
          state_d   = RD_WAIT;
        end
      end
      WR_WAIT: begin
        // A valid in the same cycle as the timeout wins over the timeout.
        if (lb_wr_valid) begin
          state_d = IDLE;
        end else if (timeout_now) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      RD_WAIT: begin
        if (lb_rd_valid) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end else if (timeout_now) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register, strobes and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      lb_wr_en          <= 1'b0;
      lb_rd_en          <= 1'b0;
      lb_addr           <= '0;
      lb_wr_data        <= '0;
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= '0;
    end else begin
      state_q  <= state_d;
      lb_wr_en <= wr_accept;
      lb_rd_en <= rd_accept;

      if (wr_accept || rd_accept) begin
        lb_addr <= avs_address;
      end
      if (wr_accept) begin
        lb_wr_data <= avs_writedata;
      end

      // Only reads return data; a timed-out write completes silently.
      avs_readdatavalid <= rd_done || (timeout_hit && (state_q == RD_WAIT));
      if (rd_done) begin
        avs_readdata <= lb_rd_data;
      end else if (timeout_hit && (state_q == RD_WAIT)) begin
        avs_readdata <= DEFAULT_DATA_VAL;
      end
    end
  end

`ifdef CORTEX_LB_BRIDGE_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Wait counter and timeout statistics
  // ---------------------------------------------------------------------------
  logic [15:0] wait_cnt_q;

  assign timeout_now = (wait_cnt_q == TIMEOUT_LAST);

  // Counts cycles spent waiting without a response. It restarts on every
  // accepted command, so its value in the first wait cycle is zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (wr_accept || rd_accept) begin
      wait_cnt_q <= '0;
    end else if ((state_q != IDLE) && (state_d == state_q)) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  // A clear in the same cycle as a timeout takes precedence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_flag <= 1'b0;
      timeout_cnt  <= '0;
    end else if (timeout_clr) begin
      timeout_flag <= 1'b0;
      timeout_cnt  <= '0;
    end else if (timeout_hit) begin
      timeout_flag <= 1'b1;
      if (timeout_cnt != 8'hff) begin
        timeout_cnt <= timeout_cnt + 8'd1;
      end
    end
  end
`else
  // Without the timeout feature the bridge waits for the cortex forever.
  assign timeout_now  = 1'b0;
  assign timeout_flag = 1'b0;
  assign timeout_cnt  = '0;

  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{timeout_clr, TIMEOUT_LAST};
`endif

endmodule

// File: tb/tb_cortex_lb_bridge.sv
// -----------------------------------------------------------------------------
// tb_cortex_lb_bridge
//
// Directed bench for cortex_lb_bridge. Inputs are driven 1 ns after a rising
// edge and outputs sampled at the same point, so "cycle N" below means the
// interval that ends with the edge sampling the host command.
// Timeout scenarios are built only with CORTEX_LB_BRIDGE_TIMEOUT_EN; the
// default build checks the wait-forever behaviour instead.
// -----------------------------------------------------------------------------
module tb_cortex_lb_bridge;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned TO = 64;
  localparam logic [31:0] DEF_VAL = 32'hdeadbabe;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [DW-1:0] avs_writedata;
  logic          avs_waitrequest;
  logic          avs_readdatavalid;
  logic [DW-1:0] avs_readdata;
  logic          lb_wr_en;
  logic          lb_rd_en;
  logic [AW-1:0] lb_addr;
  logic [DW-1:0] lb_wr_data;
  logic          lb_wr_valid;
  logic          lb_rd_valid;
  logic [DW-1:0] lb_rd_data;
  logic          timeout_clr;
  logic          timeout_flag;
  logic [7:0]    timeout_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  cortex_lb_bridge #(
    .LB_DATA_W        (DW),
    .LB_ADDR_W        (AW),
    .TIMEOUT_CYCLES   (TO),
    .DEFAULT_DATA_VAL (DEF_VAL)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_readdata      (avs_readdata),
    .lb_wr_en          (lb_wr_en),
    .lb_rd_en          (lb_rd_en),
    .lb_addr           (lb_addr),
    .lb_wr_data        (lb_wr_data),
    .lb_wr_valid       (lb_wr_valid),
    .lb_rd_valid       (lb_rd_valid),
    .lb_rd_data        (lb_rd_data),
    .timeout_clr       (timeout_clr),
    .timeout_flag      (timeout_flag),
    .timeout_cnt       (timeout_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 'h%08h, expected 'h%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a host command in the current cycle; returns in cycle N+1 with
  // the request withdrawn.
  task automatic host_cmd(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    avs_read      = rd;
    avs_write     = wr;
    avs_address   = a;
    avs_writedata = d;
    tick();
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  // Safety net: the directed flow below is fixed-length, this only fires if
  // the simulator somehow stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2 ms");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    lb_wr_valid   = 1'b0;
    lb_rd_valid   = 1'b0;
    lb_rd_data    = '0;
    timeout_clr   = 1'b0;
    repeat (3) tick();

    // ---- reset state ----
    check("rst_waitreq", 32'(avs_waitrequest), 32'd0);
    check("rst_rdv",     32'(avs_readdatavalid), 32'd0);
    check("rst_strobes", 32'({lb_wr_en, lb_rd_en}), 32'd0);
    check("rst_addr",    32'(lb_addr), 32'd0);
    check("rst_wdata",   lb_wr_data, 32'd0);
    check("rst_rdata",   avs_readdata, 32'd0);
    check("rst_tflag",   32'(timeout_flag), 32'd0);
    check("rst_tcnt",    32'(timeout_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // ---- write 'h1004 <- 'ha5, wr_valid at N+3 ----
    check("wr_idle_waitreq", 32'(avs_waitrequest), 32'd0);
    host_cmd(1'b0, 1'b1, 16'h1004, 32'h0000_00a5);            // now N+1
    check("wr_n1_wr_en",  32'(lb_wr_en), 32'd1);
    check("wr_n1_rd_en",  32'(lb_rd_en), 32'd0);
    check("wr_n1_addr",   32'(lb_addr), 32'h1004);
    check("wr_n1_data",   lb_wr_data, 32'h0000_00a5);
    check("wr_n1_waitreq", 32'(avs_waitrequest), 32'd1);
    lb_rd_valid = 1'b1;                                        // ignored in WR_WAIT
    tick();                                                    // N+2
    lb_rd_valid = 1'b0;
    check("wr_n2_wr_en",  32'(lb_wr_en), 32'd0);
    check("wr_n2_waitreq", 32'(avs_waitrequest), 32'd1);
    check("wr_n2_addr_hold", 32'(lb_addr), 32'h1004);
    tick();                                                    // N+3
    check("wr_n3_waitreq", 32'(avs_waitrequest), 32'd1);
    check("wr_n3_rdv",    32'(avs_readdatavalid), 32'd0);
    lb_wr_valid = 1'b1;
    tick();                                                    // N+4
    lb_wr_valid = 1'b0;
    check("wr_n4_waitreq", 32'(avs_waitrequest), 32'd0);
    check("wr_n4_rdv",    32'(avs_readdatavalid), 32'd0);

    // ---- read 'h2000, combinational response in the strobe cycle ----
    host_cmd(1'b1, 1'b0, 16'h2000, 32'h0);                     // N+1
    check("rd_n1_rd_en",  32'(lb_rd_en), 32'd1);
    check("rd_n1_wr_en",  32'(lb_wr_en), 32'd0);
    check("rd_n1_addr",   32'(lb_addr), 32'h2000);
    lb_rd_valid = 1'b1;
    lb_rd_data  = 32'h1234_5678;
    tick();                                                    // N+2
    lb_rd_valid = 1'b0;
    lb_rd_data  = 32'h0;
    check("rd_n2_rdv",     32'(avs_readdatavalid), 32'd1);
    check("rd_n2_rdata",   avs_readdata, 32'h1234_5678);
    check("rd_n2_waitreq", 32'(avs_waitrequest), 32'd0);
    check("rd_n2_rd_en",   32'(lb_rd_en), 32'd0);
    tick();                                                    // N+3
    check("rd_n3_rdv",     32'(avs_readdatavalid), 32'd0);
    check("rd_n3_hold",    avs_readdata, 32'h1234_5678);

    // ---- valids in IDLE are ignored ----
    lb_rd_valid = 1'b1;
    lb_wr_valid = 1'b1;
    lb_rd_data  = 32'h5555_aaaa;
    tick();
    lb_rd_valid = 1'b0;
    lb_wr_valid = 1'b0;
    check("idle_valid_rdv",   32'(avs_readdatavalid), 32'd0);
    check("idle_valid_rdata", avs_readdata, 32'h1234_5678);
    check("idle_valid_wreq",  32'(avs_waitrequest), 32'd0);

    // ---- read and write together: only the write runs ----
    host_cmd(1'b1, 1'b1, 16'h3000, 32'h0000_0055);             // N+1
    check("rw_n1_wr_en", 32'(lb_wr_en), 32'd1);
    check("rw_n1_rd_en", 32'(lb_rd_en), 32'd0);
    check("rw_n1_data",  lb_wr_data, 32'h0000_0055);
    lb_wr_valid = 1'b1;
    tick();                                                    // N+2
    lb_wr_valid = 1'b0;
    check("rw_n2_waitreq", 32'(avs_waitrequest), 32'd0);
    check("rw_n2_rdv",     32'(avs_readdatavalid), 32'd0);
    tick();
    check("rw_n3_rd_en",   32'(lb_rd_en), 32'd0);
    check("rw_n3_rdv",     32'(avs_readdatavalid), 32'd0);

    // ---- reset during RD_WAIT aborts the read ----
    host_cmd(1'b1, 1'b0, 16'h4000, 32'h0);                     // N+1
    tick();                                                    // N+2
    rst_n = 1'b0;
    tick();                                                    // N+3
    rst_n = 1'b1;
    check("rstmid_waitreq", 32'(avs_waitrequest), 32'd0);
    check("rstmid_rdv",     32'(avs_readdatavalid), 32'd0);
    check("rstmid_rdata",   avs_readdata, 32'd0);
    check("rstmid_addr",    32'(lb_addr), 32'd0);
    lb_rd_valid = 1'b1;
    lb_rd_data  = 32'h7777_7777;
    tick();                                                    // N+4
    lb_rd_valid = 1'b0;
    check("rstmid_n4_strobes", 32'({lb_wr_en, lb_rd_en}), 32'd0);
    check("rstmid_n4_rdv",     32'(avs_readdatavalid), 32'd0);
    tick();                                                    // N+5
    check("rstmid_n5_rdv",     32'(avs_readdatavalid), 32'd0);
    check("rstmid_n5_waitreq", 32'(avs_waitrequest), 32'd0);

`ifdef CORTEX_LB_BRIDGE_TIMEOUT_EN
    // ---- unanswered read times out at N+TO, returns default at N+TO+1 ----
    host_cmd(1'b1, 1'b0, 16'h2000, 32'h0);                     // N+1
    repeat (TO - 1) tick();                                    // N+TO
    check("to_last_rdv",     32'(avs_readdatavalid), 32'd0);
    check("to_last_waitreq", 32'(avs_waitrequest), 32'd1);
    check("to_last_tflag",   32'(timeout_flag), 32'd0);
    tick();                                                    // N+TO+1
    check("to_rdv",     32'(avs_readdatavalid), 32'd1);
    check("to_rdata",   avs_readdata, DEF_VAL);
    check("to_waitreq", 32'(avs_waitrequest), 32'd0);
    check("to_tflag",   32'(timeout_flag), 32'd1);
    check("to_tcnt",    32'(timeout_cnt), 32'd1);
    repeat (40) tick();
    lb_rd_valid = 1'b1;                                        // late response
    lb_rd_data  = 32'h1111_2222;
    tick();
    lb_rd_valid = 1'b0;
    tick();
    check("late_rdv",   32'(avs_readdatavalid), 32'd0);
    check("late_rdata", avs_readdata, DEF_VAL);

    // ---- valid on the timeout cycle wins ----
    host_cmd(1'b1, 1'b0, 16'h2004, 32'h0);                     // N+1
    repeat (TO - 1) tick();                                    // N+TO
    lb_rd_valid = 1'b1;
    lb_rd_data  = 32'hcafe_0001;
    tick();                                                    // N+TO+1
    lb_rd_valid = 1'b0;
    check("vwin_rdv",   32'(avs_readdatavalid), 32'd1);
    check("vwin_rdata", avs_readdata, 32'hcafe_0001);
    check("vwin_tcnt",  32'(timeout_cnt), 32'd1);

    // ---- 260 unanswered writes saturate the count ----
    for (int i = 0; i < 260; i++) begin
      host_cmd(1'b0, 1'b1, 16'(i), 32'(i));                    // N+1
      repeat (TO) tick();                                      // N+TO+1, idle
    end
    check("sat_tcnt",    32'(timeout_cnt), 32'd255);
    check("sat_tflag",   32'(timeout_flag), 32'd1);
    check("sat_waitreq", 32'(avs_waitrequest), 32'd0);
    check("sat_rdv",     32'(avs_readdatavalid), 32'd0);

    // ---- clear on the same cycle as another timeout: clear wins ----
    host_cmd(1'b0, 1'b1, 16'h5000, 32'h0);                     // N+1
    repeat (TO - 1) tick();                                    // N+TO
    timeout_clr = 1'b1;
    tick();                                                    // N+TO+1
    timeout_clr = 1'b0;
    check("clr_tflag",   32'(timeout_flag), 32'd0);
    check("clr_tcnt",    32'(timeout_cnt), 32'd0);
    check("clr_waitreq", 32'(avs_waitrequest), 32'd0);
`else
    // ---- no timeout: an unanswered read waits indefinitely ----
    host_cmd(1'b1, 1'b0, 16'h2000, 32'h0);                     // N+1
    repeat (300) tick();
    check("nto_waitreq", 32'(avs_waitrequest), 32'd1);
    check("nto_rdv",     32'(avs_readdatavalid), 32'd0);
    check("nto_tflag",   32'(timeout_flag), 32'd0);
    check("nto_tcnt",    32'(timeout_cnt), 32'd0);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    check("nto_clr_waitreq", 32'(avs_waitrequest), 32'd1);
    lb_rd_valid = 1'b1;
    lb_rd_data  = 32'h0bad_f00d;
    tick();
    lb_rd_valid = 1'b0;
    check("nto_rdv_done", 32'(avs_readdatavalid), 32'd1);
    check("nto_rdata",    avs_readdata, 32'h0bad_f00d);
    check("nto_idle",     32'(avs_waitrequest), 32'd0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
